// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a 2-entry skid buffer on the output.
// Optional feature: define IMM_GEN_CSR_EN to decode CSR*I instructions as fmt Z.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instruction_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_Z     = 3'd7;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // state | meaning
    // EMPTY | nothing buffered, out_valid_o low
    // ONE   | output register holds an entry
    // FULL  | output register and skid register both hold entries
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_d;
    logic [2:0]      fmt_d;
    logic            illegal_d;

    assign opcode   = instruction_i[6:0];
    assign funct3   = instruction_i[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        imm_d = '0;
        fmt_d = FMT_NONE;
        case (opcode)
            OPC_OP_IMM: begin
                if (is_shift) begin
                    fmt_d = FMT_SHAMT;
                    if (XLEN == 64) imm_d = {{(XLEN-6){1'b0}}, instruction_i[25:20]};
                    else            imm_d = {{(XLEN-5){1'b0}}, instruction_i[24:20]};
                end else begin
                    fmt_d = FMT_I;
                    imm_d = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt_d = FMT_I;
                imm_d = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:20]};
            end
            OPC_OP_IMM_32: begin
                // word-sized ops only exist on RV64; on RV32 this opcode is not an immediate
                if (XLEN == 64) begin
                    if (is_shift) begin
                        fmt_d = FMT_SHAMT;
                        imm_d = {{(XLEN-5){1'b0}}, instruction_i[24:20]};
                    end else begin
                        fmt_d = FMT_I;
                        imm_d = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:20]};
                    end
                end
            end
            OPC_STORE: begin
                fmt_d = FMT_S;
                imm_d = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:25],
                         instruction_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_d = FMT_B;
                imm_d = {{(XLEN-12){instruction_i[31]}}, instruction_i[7],
                         instruction_i[30:25], instruction_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_d = FMT_U;
                imm_d = {{(XLEN-31){instruction_i[31]}}, instruction_i[30:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_d = FMT_J;
                imm_d = {{(XLEN-20){instruction_i[31]}}, instruction_i[19:12],
                         instruction_i[20], instruction_i[30:21], 1'b0};
            end
`ifdef IMM_GEN_CSR_EN
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    fmt_d = FMT_Z;
                    imm_d = {{(XLEN-5){1'b0}}, instruction_i[19:15]};
                end
            end
`else
            OPC_SYSTEM: begin
                fmt_d = FMT_NONE;
            end
`endif
            default: begin
                fmt_d = FMT_NONE;
            end
        endcase
    end

    assign illegal_d = (fmt_d == FMT_NONE);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_FULL;
                else if (pop && !push) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_EMPTY;
            in_ready_o   <= 1'b1;
            out_valid_o  <= 1'b0;
            imm_o        <= '0;
            fmt_o        <= FMT_NONE;
            illegal_o    <= 1'b0;
            tag_o        <= '0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else begin
            state       <= state_nxt;
            // ready is a pure function of the next state, so it never sees out_ready_i combinationally
            in_ready_o  <= (state_nxt != ST_FULL);
            out_valid_o <= (state_nxt != ST_EMPTY);
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        imm_o     <= imm_d;
                        fmt_o     <= fmt_d;
                        illegal_o <= illegal_d;
                        tag_o     <= tag_i;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        imm_o     <= imm_d;
                        fmt_o     <= fmt_d;
                        illegal_o <= illegal_d;
                        tag_o     <= tag_i;
                    end else if (push) begin
                        skid_imm     <= imm_d;
                        skid_fmt     <= fmt_d;
                        skid_illegal <= illegal_d;
                        skid_tag     <= tag_i;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        imm_o     <= skid_imm;
                        fmt_o     <= skid_fmt;
                        illegal_o <= skid_illegal;
                        tag_o     <= skid_tag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed immediate vectors, backpressure ordering, reset in FULL,
// then random traffic against an arithmetic reference model and a FIFO scoreboard.
module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      instruction_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  imm_o;
    logic [2:0]       fmt_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instruction_i(instruction_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .imm_o(imm_o), .fmt_o(fmt_o), .illegal_o(illegal_o), .tag_o(tag_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             sb[$];
    logic [TAG_W-1:0] popped[$];
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic longint sext(input longint raw, input int bits);
        if (raw >= (longint'(1) <<< (bits - 1))) return raw - (longint'(1) <<< bits);
        return raw;
    endfunction

    // Reference decode computed from field arithmetic rather than bit concatenation.
    function automatic exp_t model(input logic [31:0] ins, input logic [TAG_W-1:0] tg);
        exp_t   e;
        longint v;
        int     op;
        int     f3;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        v = 0;
        e.fmt = 3'd0;
        case (op)
            'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    e.fmt = 3'd6;
                    v = (XLEN == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    e.fmt = 3'd1;
                    v = sext(longint'(ins[31:20]), 12);
                end
            end
            'h03, 'h67: begin
                e.fmt = 3'd1;
                v = sext(longint'(ins[31:20]), 12);
            end
            'h1B: begin
                if (XLEN == 64) begin
                    if (f3 == 1 || f3 == 5) begin
                        e.fmt = 3'd6;
                        v = longint'(ins[24:20]);
                    end else begin
                        e.fmt = 3'd1;
                        v = sext(longint'(ins[31:20]), 12);
                    end
                end
            end
            'h23: begin
                e.fmt = 3'd2;
                v = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            end
            'h63: begin
                e.fmt = 3'd3;
                v = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                         longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            end
            'h37, 'h17: begin
                e.fmt = 3'd4;
                v = sext(longint'(ins[31:12]) * 4096, 32);
            end
            'h6F: begin
                e.fmt = 3'd5;
                v = sext(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                         longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            end
`ifdef IMM_GEN_CSR_EN
            'h73: begin
                if (f3 >= 4) begin
                    e.fmt = 3'd7;
                    v = longint'(ins[19:15]);
                end
            end
`endif
            default: e.fmt = 3'd0;
        endcase
        e.imm = v[XLEN-1:0];
        e.ill = (e.fmt == 3'd0);
        e.tag = tg;
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid_o), 64'(sb.size() > 0));
        chk("in_ready", 64'(in_ready_o), 64'(sb.size() < 2));
        if (out_valid_o && sb.size() > 0) begin
            chk("imm", 64'(imm_o), 64'(sb[0].imm));
            chk("fmt", 64'(fmt_o), 64'(sb[0].fmt));
            chk("illegal", 64'(illegal_o), 64'(sb[0].ill));
            chk("tag", 64'(tag_o), 64'(sb[0].tag));
        end
    endtask

    // Called at a negedge; checks, drives one cycle of stimulus, returns at the next negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [TAG_W-1:0] tg,
                        input logic rdy);
        bit push;
        bit pop;
        check_outputs();
        in_valid_i    = v;
        instruction_i = ins;
        tag_i         = tg;
        out_ready_i   = rdy;
        push = v && (sb.size() < 2);
        pop  = rdy && (sb.size() > 0);
        if (pop) popped.push_back(tag_o);
        @(posedge clk_i);
        if (pop) void'(sb.pop_front());
        if (push) sb.push_back(model(ins, tg));
        @(negedge clk_i);
    endtask

    task automatic directed(input logic [31:0] ins, input logic [XLEN-1:0] e_imm,
                            input logic [2:0] e_fmt, input logic e_ill, input logic [TAG_W-1:0] tg);
        step(1'b1, ins, tg, 1'b1);
        chk("dir_valid", 64'(out_valid_o), 64'd1);
        chk("dir_imm", 64'(imm_o), 64'(e_imm));
        chk("dir_fmt", 64'(fmt_o), 64'(e_fmt));
        chk("dir_ill", 64'(illegal_o), 64'(e_ill));
        chk("dir_tag", 64'(tag_o), 64'(tg));
        step(1'b0, 32'h0, '0, 1'b1);
    endtask

    logic [6:0] opcodes [12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};

    initial begin
        rst_i         = 1'b1;
        in_valid_i    = 1'b0;
        instruction_i = '0;
        tag_i         = '0;
        out_ready_i   = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_imm", 64'(imm_o), 64'd0);
        chk("rst_tag", 64'(tag_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        directed(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h1000);
        directed(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 32'h1004);
        directed(32'h0010006F, 32'h00000800, 3'd5, 1'b0, 32'h1008);
        directed(32'h123452B7, 32'h12345000, 3'd4, 1'b0, 32'h100C);
        directed(32'h4030D093, 32'h00000003, 3'd6, 1'b0, 32'h1010);
        directed(32'h00000033, 32'h00000000, 3'd0, 1'b1, 32'h1014);
`ifdef IMM_GEN_CSR_EN
        directed(32'h00F0D073, 32'h00000001, 3'd7, 1'b0, 32'h1018);
`else
        directed(32'h00F0D073, 32'h00000000, 3'd0, 1'b1, 32'h1018);
`endif

        // backpressure: three pushes with the consumer stalled
        popped.delete();
        step(1'b1, 32'h00100093, 32'd1, 1'b0);
        step(1'b1, 32'h00200093, 32'd2, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
        step(1'b1, 32'h00300093, 32'd3, 1'b0);
        chk("bp_hold_tag", 64'(tag_o), 64'd1);
        step(1'b1, 32'h00300093, 32'd3, 1'b1);
        step(1'b1, 32'h00300093, 32'd3, 1'b1);
        step(1'b0, 32'h0, 32'd0, 1'b1);
        step(1'b0, 32'h0, 32'd0, 1'b1);
        chk("bp_count", 64'(popped.size()), 64'd3);
        for (int k = 0; k < 3 && k < popped.size(); k++)
            chk("bp_order", 64'(popped[k]), 64'(k + 1));

        // reset in the middle of a cycle while FULL
        step(1'b1, 32'h00A00093, 32'd10, 1'b0);
        step(1'b1, 32'h00B00093, 32'd11, 1'b0);
        chk("full_in_ready", 64'(in_ready_o), 64'd0);
        in_valid_i    = 1'b1;
        instruction_i = 32'h06300093;
        tag_i         = 32'd99;
        out_ready_i   = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_ready", 64'(in_ready_o), 64'd1);
        chk("mid_rst_tag", 64'(tag_o), 64'd0);
        chk("mid_rst_fmt", 64'(fmt_o), 64'd0);
        sb.delete();
        @(negedge clk_i);
        in_valid_i = 1'b0;
        rst_i      = 1'b0;
        @(negedge clk_i);
        step(1'b1, 32'h01400093, 32'd20, 1'b1);
        chk("post_rst_tag", 64'(tag_o), 64'd20);
        step(1'b0, 32'h0, 32'd0, 1'b1);
        chk("post_rst_empty", 64'(out_valid_o), 64'd0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0] = opcodes[$urandom_range(0, 11)];
            step(1'($urandom_range(0, 3) != 0), ins, TAG_W'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < 4; n++) step(1'b0, 32'h0, '0, 1'b1);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
